// File: rtl/dlx_run_sequencer_if.sv
// rtl/dlx_run_sequencer_if.sv - control/observe bundle between the DLX run sequencer and its harness
//
// master: the sequencer (samples start/expect/pc/reg_data, drives DUT reset and status)
// slave : the harness / DUT side (drives start/expect/pc/reg_data, observes status)
//   start_i     one-cycle start pulse
//   exp_sel_i   register index to check, sampled with start_i
//   exp_val_i   expected register value, sampled with start_i
//   pc_i        DUT program counter
//   reg_data_i  DUT register-file read data for reg_sel_o
//   dut_reset_o DUT reset (active level set by the sequencer)
//   reg_sel_o   register index presented to the DUT
//   running_o   high while the program runs
//   done_o      high once a result is available
//   pass_o      register check result, valid with done_o
//   timeout_o   run hit the cycle limit, valid with done_o
//   cycles_o    run cycle count
//   halt_pc_o   PC captured at halt or timeout
interface dlx_run_sequencer_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic              start_i;
    logic [SEL_W-1:0]  exp_sel_i;
    logic [DATA_W-1:0] exp_val_i;
    logic [ADDR_W-1:0] pc_i;
    logic [DATA_W-1:0] reg_data_i;
    logic              dut_reset_o;
    logic [SEL_W-1:0]  reg_sel_o;
    logic              running_o;
    logic              done_o;
    logic              pass_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  cycles_o;
    logic [ADDR_W-1:0] halt_pc_o;

    modport master (
        input  start_i, exp_sel_i, exp_val_i, pc_i, reg_data_i,
        output dut_reset_o, reg_sel_o, running_o, done_o, pass_o, timeout_o, cycles_o, halt_pc_o
    );

    modport slave (
        output start_i, exp_sel_i, exp_val_i, pc_i, reg_data_i,
        input  dut_reset_o, reg_sel_o, running_o, done_o, pass_o, timeout_o, cycles_o, halt_pc_o
    );
endinterface

// File: rtl/dlx_run_sequencer.sv
// rtl/dlx_run_sequencer.sv - reset sequencing, run/halt/timeout control and result check for a DLX core
//
// Ports:
//   clock_i  clock
//   reset_i  synchronous active-high reset
//   bus      dlx_run_sequencer_if.master (start/expect inputs, pc/reg_data from DUT,
//            dut_reset/reg_sel to DUT, running/done/pass/timeout/cycles/halt_pc status)
// After start_i the DUT sees RST_PULSES reset pulses of RST_CYCLES each, separated by
// GAP_CYCLES; the program then runs until halt (HALT_ADDR or a stalled PC) or TIMEOUT.
// On halt the selected register is compared against the expected value.
module dlx_run_sequencer #(
    parameter int               ADDR_W         = 32,
    parameter int               DATA_W         = 32,
    parameter int               NUM_REGS       = 32,
    parameter int               CNT_W          = 32,
    parameter int               RST_CYCLES     = 3,
    parameter int               RST_PULSES     = 2,
    parameter int               GAP_CYCLES     = 2,
    parameter bit               DUT_RST_ACTIVE = 1'b0,
    parameter logic [ADDR_W-1:0] HALT_ADDR     = ADDR_W'(32'hFFFF_FFFC),
    parameter int               STALL_LIMIT    = 8,
    parameter int               TIMEOUT        = 1000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    dlx_run_sequencer_if.master bus
);
    localparam int SEL_W = $clog2(NUM_REGS);

    localparam logic [15:0]      RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]      PULSES     = 16'(RST_PULSES);
    localparam logic [15:0]      STALL_LAST = 16'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TMO_CNT    = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_GAP, S_RUN, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       phase_q, phase_d;
    logic [15:0]       pulse_q, pulse_d;
    logic [15:0]       stall_q, stall_d;
    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
    logic [DATA_W-1:0] exp_val_q, exp_val_d;
    logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic              dut_reset_q, dut_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic              start_ok;
    logic              phase_last;
    logic              last_pulse;
    logic [15:0]       stall_now;
    logic              halt;
    logic              tmo;

    // Conditions shared by the next-state and output logic.
    always_comb begin
        start_ok   = bus.start_i && (state_q == S_IDLE || state_q == S_DONE);
        phase_last = (state_q == S_ASSERT) ? (phase_q == RST_LAST) : (phase_q == GAP_LAST);
        last_pulse = (pulse_q + 16'd1) >= PULSES;
        // cycles_q is 1 only on the first RUN cycle, which always counts as a PC change.
        stall_now  = (cycles_q == CNT_W'(1) || bus.pc_i != prev_pc_q) ? 16'd0 : stall_q + 16'd1;
        halt       = (bus.pc_i == HALT_ADDR) || (stall_now == STALL_LAST);
        tmo        = (cycles_q == TMO_CNT);
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            pulse_q     <= '0;
            stall_q     <= '0;
            prev_pc_q   <= '0;
            exp_val_q   <= '0;
            reg_sel_q   <= '0;
            cycles_q    <= '0;
            halt_pc_q   <= '0;
            dut_reset_q <= DUT_RST_ACTIVE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_q     <= pulse_d;
            stall_q     <= stall_d;
            prev_pc_q   <= prev_pc_d;
            exp_val_q   <= exp_val_d;
            reg_sel_q   <= reg_sel_d;
            cycles_q    <= cycles_d;
            halt_pc_q   <= halt_pc_d;
            dut_reset_q <= dut_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_ASSERT;
            S_ASSERT: if (phase_last) state_d = last_pulse ? S_RUN : S_GAP;
            S_GAP:    if (phase_last) state_d = S_ASSERT;
            S_RUN: begin
                // Halt takes priority over a coincident timeout.
                if (halt)     state_d = S_CHECK;
                else if (tmo) state_d = S_DONE;
            end
            S_CHECK:  state_d = S_DONE;
            S_DONE:   if (start_ok) state_d = S_ASSERT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; outputs track the state being entered.
    always_comb begin
        phase_d     = 16'd0;
        pulse_d     = pulse_q;
        stall_d     = stall_q;
        prev_pc_d   = prev_pc_q;
        exp_val_d   = exp_val_q;
        reg_sel_d   = reg_sel_q;
        cycles_d    = cycles_q;
        halt_pc_d   = halt_pc_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        dut_reset_d = (state_d == S_IDLE || state_d == S_ASSERT) ? DUT_RST_ACTIVE : ~DUT_RST_ACTIVE;
        running_d   = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);

        if ((state_q == S_ASSERT || state_q == S_GAP) && state_d == state_q)
            phase_d = phase_q + 16'd1;

        if (start_ok) begin
            pulse_d   = 16'd0;
            exp_val_d = bus.exp_val_i;
            reg_sel_d = bus.exp_sel_i;
            cycles_d  = '0;
            halt_pc_d = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == S_ASSERT && phase_last) begin
            pulse_d = pulse_q + 16'd1;
            if (state_d == S_RUN)
                cycles_d = CNT_W'(1);
        end else if (state_q == S_RUN) begin
            stall_d   = stall_now;
            prev_pc_d = bus.pc_i;
            if (halt) begin
                halt_pc_d = bus.pc_i;
            end else if (tmo) begin
                halt_pc_d = bus.pc_i;
                pass_d    = 1'b0;
                timeout_d = 1'b1;
            end else begin
                cycles_d = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + CNT_W'(1);
            end
        end else if (state_q == S_CHECK) begin
            pass_d    = (bus.reg_data_i == exp_val_q);
            timeout_d = 1'b0;
        end
    end

    assign bus.dut_reset_o = dut_reset_q;
    assign bus.reg_sel_o   = reg_sel_q;
    assign bus.running_o   = running_q;
    assign bus.done_o      = done_q;
    assign bus.pass_o      = pass_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.cycles_o    = cycles_q;
    assign bus.halt_pc_o   = halt_pc_q;
endmodule
